uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout in clock cycles (used only with UART_CMD_TIMEOUT_EN).
REQ-002 SHALL have port: clock  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: rx_byte  input  8  received UART byte; rx_valid  input  1  rx_byte valid; rx_ready  output  1  controller accepts rx_byte.
REQ-005 SHALL have ports: tx_byte  output  8  response byte; tx_valid  output  1  tx_byte valid; tx_ready  input  1  UART accepts tx_byte.
REQ-006 SHALL have ports: bus_addr  output  8  target address; bus_wdata  output  8  write data; bus_write  output  1  1 = write, 0 = read; bus_valid  output  1  request pending; bus_ready  input  1  request completes this cycle; bus_rdata  input  8  read data, valid with bus_ready on reads.

Function
REQ-007 SHALL treat a transfer as occurring on any cycle where valid and ready are both high, for the rx, tx and bus interfaces alike.
REQ-008 SHALL implement states IDLE, GET_ADDR, GET_DATA, BUS, RESP.
REQ-009 SHALL drive rx_ready high only in IDLE, GET_ADDR and GET_DATA, and drive rx_ready combinationally from the state only.
REQ-010 SHALL, in IDLE, on an rx transfer: 0x57 ('W') -> GET_ADDR with write flag set; 0x52 ('R') -> GET_ADDR with write flag clear; any other byte -> RESP with tx_byte = 0x3F ('?').
REQ-011 SHALL, in GET_ADDR, on an rx transfer, latch bus_addr, then go to GET_DATA if writing, else to BUS.
REQ-012 SHALL, in GET_DATA, on an rx transfer, latch bus_wdata and go to BUS.
REQ-013 SHALL assert bus_valid throughout BUS, holding bus_addr, bus_wdata and bus_write stable until bus_ready.
REQ-014 SHALL, on a bus transfer, go to RESP with tx_byte = 0x4B ('K') for a write or bus_rdata captured that cycle for a read.
REQ-015 SHALL assert tx_valid throughout RESP with tx_byte stable, return to IDLE on the tx transfer, and accept no rx byte in that cycle.
REQ-016 SHALL have a minimum latency of one cycle from bus transfer to tx_valid, and one cycle from tx transfer to rx_ready.
REQ-017 SHALL ignore rx_byte whenever rx_ready is low; bytes are not buffered.

Reset
REQ-018 SHALL, on reset high at a clock edge, enter IDLE regardless of state and drive rx_ready=1, tx_valid=0, bus_valid=0, tx_byte=0, bus_addr=0, bus_wdata=0, bus_write=0.
REQ-019 SHALL, when reset occurs mid-command (including BUS with bus_valid high), drop the request and emit no response.

Configuration
REQ-020 SHALL, with UART_CMD_TIMEOUT_EN defined, count cycles in GET_ADDR and GET_DATA without an rx transfer. The count clears on each rx transfer.
REQ-021 SHALL, when that count reaches TIMEOUT_CYCLES, go to IDLE and discard the partial command without a response. An rx transfer in the same cycle takes priority over the timeout.
REQ-022 SHALL, without UART_CMD_TIMEOUT_EN, contain no timeout counter and wait in GET_ADDR and GET_DATA indefinitely.

Structure
REQ-023 SHALL take the state enum and opcode/response constants (OP_WRITE=0x57, OP_READ=0x52, RSP_OK=0x4B, RSP_ERR=0x3F) from shared package uart_cmd_pkg.
REQ-024 SHALL place the timeout counter in sub-module uart_cmd_timer (inputs clock, reset, clear, enable; output expired), instantiated only under UART_CMD_TIMEOUT_EN.

Verification
REQ-025 SHALL pass this scenario: rx 0x57,0x10,0xA5 with bus_ready=1 -> one bus transfer with addr=0x10, wdata=0xA5, write=1; then tx_byte=0x4B.
REQ-026 SHALL pass this scenario: rx 0x52,0x22; bus_ready held low 5 cycles, then high with bus_rdata=0x5C -> bus_valid high 6 cycles with stable addr; then tx_byte=0x5C.
REQ-027 SHALL pass this scenario: rx 0x00 -> tx_byte=0x3F; a following 0x52,0x01 is parsed as a normal read.
REQ-028 SHALL pass this scenario: tx_ready held low 10 cycles in RESP -> tx_valid and tx_byte stable; rx_ready=0 throughout; an rx_valid pulse is ignored.
REQ-029 SHALL pass this scenario: reset pulsed while in BUS -> next cycle bus_valid=0, rx_ready=1, and no tx_valid follows.
REQ-030 SHALL pass this scenario, with UART_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=8: rx 0x57 then idle 8 cycles -> back in IDLE; next 0x52,0x03 performs a read.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command controller: FSM state encoding,
// command opcodes and single-byte response codes.
package uart_cmd_pkg;

    // Command parser states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        BUS      = 3'd3,
        RESP     = 3'd4
    } state_t;

    // Command opcodes received as the first byte of a command
    localparam logic [7:0] OP_WRITE = 8'h57;   // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;   // 'R'

    // Response codes sent back over the tx channel
    localparam logic [7:0] RSP_OK   = 8'h4B;   // 'K'
    localparam logic [7:0] RSP_ERR  = 8'h3F;   // '?'

    // True for the states in which the parser is waiting for an rx byte
    function automatic logic state_accepts_rx(input state_t s);
        return (s == IDLE) || (s == GET_ADDR) || (s == GET_DATA);
    endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter for the UART command controller.
// Counts enabled cycles since the last clear; 'expired' is high on the
// TIMEOUT_CYCLES-th consecutive enabled cycle without a clear.
module uart_cmd_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Cycle counter: restarts on clear or whenever the parser is not waiting,
    // saturates at the last count so it cannot wrap while held
    always_ff @(posedge clock) begin
        if (reset || clear || !enable) begin
            r_count <= '0;
        end else if (r_count != CNT_LAST) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // A byte arriving in the expiring cycle wins, so clear masks expiry
    assign expired = enable && !clear && (r_count == CNT_LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses 'W' addr data / 'R' addr commands from
// a byte stream, performs one bus access per command and answers with a
// single byte ('K' for writes, read data for reads, '?' for bad opcodes).
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN to build it in.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    // Received byte stream
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       rx_ready,
    // Response byte stream
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    // Simple request/ready bus master
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_write,
    output logic       bus_valid,
    input  logic       bus_ready,
    input  logic [7:0] bus_rdata
);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_write;
    logic       w_write_next;
    logic [7:0] r_addr;
    logic [7:0] w_addr_next;
    logic [7:0] r_wdata;
    logic [7:0] w_wdata_next;
    logic [7:0] r_tx_byte;
    logic [7:0] w_tx_byte_next;

    logic       w_rx_ready;
    logic       w_rx_xfer;
    logic       w_expired;

    // rx_ready depends on the state alone, never on rx_valid
    assign w_rx_ready = state_accepts_rx(r_state);
    assign w_rx_xfer  = rx_valid && w_rx_ready;

`ifdef UART_CMD_TIMEOUT_EN
    logic w_timer_en;

    // Timer runs only while waiting for an address or data byte
    assign w_timer_en = (r_state == GET_ADDR) || (r_state == GET_DATA);

    uart_cmd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_rx_xfer),
        .enable  (w_timer_en),
        .expired (w_expired)
    );
`else
    // No timeout in this build: the parser waits for the next byte forever.
    // TIMEOUT_CYCLES is kept so both builds share one parameter list.
    assign w_expired = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // State and datapath registers; reset abandons any command in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_write   <= 1'b0;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_tx_byte <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_write   <= w_write_next;
            r_addr    <= w_addr_next;
            r_wdata   <= w_wdata_next;
            r_tx_byte <= w_tx_byte_next;
        end
    end

    // Next-state and datapath-load logic; everything holds unless a
    // transfer on the interface owned by the current state occurs
    always_comb begin
        w_state_next   = r_state;
        w_write_next   = r_write;
        w_addr_next    = r_addr;
        w_wdata_next   = r_wdata;
        w_tx_byte_next = r_tx_byte;

        case (r_state)
            IDLE: begin
                if (w_rx_xfer) begin
                    if (rx_byte == OP_WRITE) begin
                        w_write_next = 1'b1;
                        w_state_next = GET_ADDR;
                    end else if (rx_byte == OP_READ) begin
                        w_write_next = 1'b0;
                        w_state_next = GET_ADDR;
                    end else begin
                        w_tx_byte_next = RSP_ERR;
                        w_state_next   = RESP;
                    end
                end
            end

            GET_ADDR: begin
                if (w_rx_xfer) begin
                    w_addr_next  = rx_byte;
                    w_state_next = r_write ? GET_DATA : BUS;
                end else if (w_expired) begin
                    // Partial command dropped silently
                    w_state_next = IDLE;
                end
            end

            GET_DATA: begin
                if (w_rx_xfer) begin
                    w_wdata_next = rx_byte;
                    w_state_next = BUS;
                end else if (w_expired) begin
                    w_state_next = IDLE;
                end
            end

            BUS: begin
                if (bus_ready) begin
                    // Read data is only valid alongside bus_ready, so it is
                    // captured in exactly this cycle
                    w_tx_byte_next = r_write ? RSP_OK : bus_rdata;
                    w_state_next   = RESP;
                end
            end

            RESP: begin
                if (tx_ready) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign rx_ready  = w_rx_ready;
    assign tx_valid  = (r_state == RESP);
    assign tx_byte   = r_tx_byte;
    assign bus_valid = (r_state == BUS);
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_write = r_write;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl. Expected bus requests and response
// bytes are queued when a command is sent and compared when the DUT
// completes the matching bus or tx transfer.
module tb_uart_cmd_ctrl;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       write;
    } bus_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_write;
    logic       bus_valid;
    logic       bus_ready;
    logic [7:0] bus_rdata;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_write (bus_write),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    bus_exp_t   exp_bus [$];
    logic [7:0] exp_tx  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int         bus_len      = 0;
    int         last_bus_len = 0;
    int         tx_len       = 0;
    int         last_tx_len  = 0;
    int         tx_seen      = 0;
    logic [7:0] bus_addr0;
    logic       bus_write0;
    logic [7:0] tx_byte0;
    bit         prev_bus_xfer = 0;
    bit         prev_tx_xfer  = 0;
    bus_exp_t   mon_e;
    logic [7:0] mon_b;

    always @(negedge clk) begin
        if (reset) begin
            bus_len       = 0;
            tx_len        = 0;
            prev_bus_xfer = 0;
            prev_tx_xfer  = 0;
        end else begin
            if (prev_bus_xfer) check("bus_to_tx_latency", tx_valid, 1);
            if (prev_tx_xfer)  check("tx_to_rx_latency", rx_ready, 1);
            prev_bus_xfer = 0;
            prev_tx_xfer  = 0;

            if (bus_valid) begin
                check("rx_ready_in_bus", rx_ready, 0);
                if (bus_len == 0) begin
                    bus_addr0  = bus_addr;
                    bus_write0 = bus_write;
                end else begin
                    check("bus_addr_stable", bus_addr, bus_addr0);
                    check("bus_write_stable", bus_write, bus_write0);
                end
                bus_len++;
                if (bus_ready) begin
                    $display("bus xfer addr=%02h wdata=%02h write=%0d cycles=%0d",
                             bus_addr, bus_wdata, bus_write, bus_len);
                    if (exp_bus.size() == 0) begin
                        check("bus_unexpected", 1, 0);
                    end else begin
                        mon_e = exp_bus.pop_front();
                        check("bus_addr", bus_addr, mon_e.addr);
                        check("bus_write", bus_write, mon_e.write);
                        if (mon_e.write) check("bus_wdata", bus_wdata, mon_e.wdata);
                    end
                    last_bus_len  = bus_len;
                    bus_len       = 0;
                    prev_bus_xfer = 1;
                end
            end

            if (tx_valid) begin
                tx_seen++;
                check("rx_ready_in_resp", rx_ready, 0);
                if (tx_len == 0) tx_byte0 = tx_byte;
                else             check("tx_byte_stable", tx_byte, tx_byte0);
                tx_len++;
                if (tx_ready) begin
                    $display("tx xfer byte=%02h cycles=%0d", tx_byte, tx_len);
                    if (exp_tx.size() == 0) begin
                        check("tx_unexpected", 1, 0);
                    end else begin
                        mon_b = exp_tx.pop_front();
                        check("tx_byte", tx_byte, mon_b);
                    end
                    last_tx_len  = tx_len;
                    tx_len       = 0;
                    prev_tx_xfer = 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        bit done   = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        while (!done && waited < 100) begin
            @(negedge clk);
            if (rx_ready) done = 1;
            @(posedge clk);
            #1;
            waited++;
        end
        rx_valid = 1'b0;
        if (!done) check("rx_accept_timeout", 0, 1);
        else       $display("rx byte %02h accepted", b);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [7:0] a, input logic [7:0] d);
        bus_exp_t e;
        e.addr = a; e.wdata = d; e.write = 1'b1;
        exp_bus.push_back(e);
        exp_tx.push_back(8'h4B);
    endtask

    task automatic push_read(input logic [7:0] a, input logic [7:0] rd);
        bus_exp_t e;
        e.addr = a; e.wdata = 8'h00; e.write = 1'b0;
        exp_bus.push_back(e);
        exp_tx.push_back(rd);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_bus.size() != 0 || exp_tx.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", exp_bus.size() + exp_tx.size(), 0);
    endtask

    // Waits at negedges for a DUT output to rise, bounded
    task automatic wait_high(input string tag, input int which);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            seen = (which == 0) ? bus_valid : tx_valid;
            n++;
        end
        if (!seen) check(tag, 0, 1);
    endtask

    logic [7:0] bad_bytes [5] = '{8'h00, 8'hFF, 8'h77, 8'h53, 8'h72};
    int         tx_snap;

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        tx_ready  = 1'b1;
        bus_ready = 1'b1;
        bus_rdata = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_bus_valid", bus_valid, 0);
        check("rst_tx_byte", tx_byte, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Write with immediate bus_ready
        push_write(8'h10, 8'hA5);
        send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
        wait_drain();
        check("write_bus_len", last_bus_len, 1);

        // Read with bus_ready held low for 5 cycles
        bus_ready = 1'b0;
        bus_rdata = 8'hEE;
        push_read(8'h22, 8'h5C);
        send_byte(8'h52); send_byte(8'h22);
        wait_high("bus_valid_wait", 0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        bus_ready = 1'b1;
        bus_rdata = 8'h5C;
        wait_drain();
        check("read_bus_len", last_bus_len, 6);

        // Unknown opcodes answered with '?', then a normal read
        foreach (bad_bytes[i]) begin
            exp_tx.push_back(8'h3F);
            send_byte(bad_bytes[i]);
            wait_drain();
        end
        bus_rdata = 8'h31;
        push_read(8'h01, 8'h31);
        send_byte(8'h52); send_byte(8'h01);
        wait_drain();

        // Response back-pressure with an ignored rx pulse
        tx_ready = 1'b0;
        push_write(8'h33, 8'h44);
        send_byte(8'h57); send_byte(8'h33); send_byte(8'h44);
        wait_high("tx_valid_wait", 1);
        @(posedge clk);
        #1;
        rx_byte  = 8'h52;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_drain();
        check("resp_hold_len", last_tx_len, 11);
        bus_rdata = 8'h9E;
        push_read(8'h05, 8'h9E);
        send_byte(8'h52); send_byte(8'h05);
        wait_drain();

        // Reset while a bus request is pending
        bus_ready = 1'b0;
        send_byte(8'h52); send_byte(8'h40);
        wait_high("bus_valid_wait2", 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_bus_valid", bus_valid, 0);
        check("rst_mid_rx_ready", rx_ready, 1);
        check("rst_mid_tx_valid", tx_valid, 0);
        check("rst_mid_bus_addr", bus_addr, 0);
        check("rst_mid_tx_byte", tx_byte, 0);
        check("rst_mid_bus_write", bus_write, 0);
        bus_ready = 1'b1;
        tx_snap   = tx_seen;
        repeat (20) @(negedge clk);
        check("no_resp_after_reset", tx_seen - tx_snap, 0);
        @(posedge clk);
        #1;

        // Gap of 7 idle cycles between bytes is always tolerated
        push_write(8'h12, 8'h34);
        send_byte(8'h57);
        idle_cycles(7);
        send_byte(8'h12);
        idle_cycles(7);
        send_byte(8'h34);
        wait_drain();

`ifdef UART_CMD_TIMEOUT_EN
        // 8 idle cycles abandon the command; next read parses normally
        send_byte(8'h57);
        idle_cycles(8);
        bus_rdata = 8'h6D;
        push_read(8'h03, 8'h6D);
        send_byte(8'h52); send_byte(8'h03);
        wait_drain();
`else
        // Without a timeout the parser waits indefinitely for the address
        push_write(8'h66, 8'h99);
        send_byte(8'h57);
        idle_cycles(40);
        send_byte(8'h66);
        idle_cycles(40);
        send_byte(8'h99);
        wait_drain();
`endif

        idle_cycles(5);
        check("final_rx_ready", rx_ready, 1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
